// File: rtl/mem_port_arbiter.sv
// Registered arbiter sharing the single main-memory line port between the D-cache and the I-cache.
// Optional MEM_ARB_ROUND_ROBIN_EN: alternate grants on simultaneous requests; default is fixed D-cache priority.
module mem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 128
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              read_Mem_data,
  input  logic              write_Mem_data,
  input  logic [ADDR_W-1:0] Addr_Mem_data,
  input  logic [LINE_W-1:0] Data_Mem_data_write,
  output logic [LINE_W-1:0] Data_Mem_data_read,
  output logic              ready_mem_data,
  input  logic              read_Mem_instr,
  input  logic              write_Mem_instr,
  input  logic [ADDR_W-1:0] Addr_Mem_instr,
  input  logic [LINE_W-1:0] Data_Mem_instr_write,
  output logic [LINE_W-1:0] Data_Mem_instr_read,
  output logic              ready_mem_instr,
  output logic              read_Mem,
  output logic              write_Mem,
  output logic [ADDR_W-1:0] Addr_Mem,
  output logic [LINE_W-1:0] Data_Mem_write,
  input  logic [LINE_W-1:0] Data_Mem_read,
  input  logic              ready_mem,
  output logic              busy,
  output logic              grant_instr
);

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_BUSY = 2'd1, ST_DONE = 2'd2} state_t;

  state_t              state_r, state_s;
  logic                grant_r, grant_s;
  logic                rd_r, rd_s;
  logic                wr_r, wr_s;
  logic [ADDR_W-1:0]   addr_r, addr_s;
  logic [LINE_W-1:0]   wdata_r, wdata_s;
  logic [LINE_W-1:0]   dread_r, dread_s;
  logic [LINE_W-1:0]   iread_r, iread_s;
  logic                dready_r, dready_s;
  logic                iready_r, iready_s;
  logic                busy_r, busy_s;
  logic                d_act_s, i_act_s, win_instr_s;
`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic                last_instr_r, last_instr_s;
`endif

  // Winner selection among active requesters
  always_comb begin
    d_act_s = read_Mem_data | write_Mem_data;
    i_act_s = read_Mem_instr | write_Mem_instr;
    if (d_act_s && i_act_s) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
      win_instr_s = ~last_instr_r;
`else
      win_instr_s = 1'b0;
`endif
    end else begin
      win_instr_s = i_act_s;
    end
  end

  // Next-state and next-register values for the IDLE/BUSY/DONE sequencer
  always_comb begin
    state_s  = state_r;
    grant_s  = grant_r;
    rd_s     = rd_r;
    wr_s     = wr_r;
    addr_s   = addr_r;
    wdata_s  = wdata_r;
    dread_s  = dread_r;
    iread_s  = iread_r;
    dready_s = 1'b0;
    iready_s = 1'b0;
    busy_s   = busy_r;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    last_instr_s = last_instr_r;
`endif
    case (state_r)
      ST_IDLE: begin
        if (d_act_s || i_act_s) begin
          state_s = ST_BUSY;
          busy_s  = 1'b1;
          grant_s = win_instr_s;
          // A combined rd+wr request performs the write only
          wr_s    = win_instr_s ? write_Mem_instr : write_Mem_data;
          rd_s    = win_instr_s ? (read_Mem_instr & ~write_Mem_instr)
                                : (read_Mem_data & ~write_Mem_data);
          addr_s  = win_instr_s ? Addr_Mem_instr : Addr_Mem_data;
          wdata_s = win_instr_s ? Data_Mem_instr_write : Data_Mem_data_write;
`ifdef MEM_ARB_ROUND_ROBIN_EN
          last_instr_s = win_instr_s;
`endif
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (ready_mem) begin
          state_s  = ST_DONE;
          rd_s     = 1'b0;
          wr_s     = 1'b0;
          iready_s = grant_r;
          dready_s = ~grant_r;
          if (rd_r && grant_r) begin
            iread_s = Data_Mem_read;
          end else if (rd_r) begin
            dread_s = Data_Mem_read;
          end else begin
            dread_s = dread_r;
          end
        end else begin
          state_s = ST_BUSY;
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
        busy_s  = 1'b0;
      end
      default: begin
        state_s = ST_IDLE;
        busy_s  = 1'b0;
        rd_s    = 1'b0;
        wr_s    = 1'b0;
      end
    endcase
  end

  // State and output registers; reset abandons any in-flight access
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r  <= ST_IDLE;
      grant_r  <= 1'b0;
      rd_r     <= 1'b0;
      wr_r     <= 1'b0;
      addr_r   <= {ADDR_W{1'b0}};
      wdata_r  <= {LINE_W{1'b0}};
      dread_r  <= {LINE_W{1'b0}};
      iread_r  <= {LINE_W{1'b0}};
      dready_r <= 1'b0;
      iready_r <= 1'b0;
      busy_r   <= 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      last_instr_r <= 1'b1;
`endif
    end else begin
      state_r  <= state_s;
      grant_r  <= grant_s;
      rd_r     <= rd_s;
      wr_r     <= wr_s;
      addr_r   <= addr_s;
      wdata_r  <= wdata_s;
      dread_r  <= dread_s;
      iread_r  <= iread_s;
      dready_r <= dready_s;
      iready_r <= iready_s;
      busy_r   <= busy_s;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      last_instr_r <= last_instr_s;
`endif
    end
  end

  assign read_Mem            = rd_r;
  assign write_Mem           = wr_r;
  assign Addr_Mem            = addr_r;
  assign Data_Mem_write      = wdata_r;
  assign Data_Mem_data_read  = dread_r;
  assign Data_Mem_instr_read = iread_r;
  assign ready_mem_data      = dready_r;
  assign ready_mem_instr     = iready_r;
  assign busy                = busy_r;
  assign grant_instr         = grant_r;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: memory model, requester tasks and issue/done scoreboards.
`timescale 1ns/1ps
module tb_mem_port_arbiter;
  localparam int ADDR_W = 32;
  localparam int LINE_W = 128;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic read_Mem_data = 1'b0, write_Mem_data = 1'b0;
  logic [ADDR_W-1:0] Addr_Mem_data = '0;
  logic [LINE_W-1:0] Data_Mem_data_write = '0, Data_Mem_data_read;
  logic ready_mem_data;
  logic read_Mem_instr = 1'b0, write_Mem_instr = 1'b0;
  logic [ADDR_W-1:0] Addr_Mem_instr = '0;
  logic [LINE_W-1:0] Data_Mem_instr_write = '0, Data_Mem_instr_read;
  logic ready_mem_instr;
  logic read_Mem, write_Mem;
  logic [ADDR_W-1:0] Addr_Mem;
  logic [LINE_W-1:0] Data_Mem_write;
  logic [LINE_W-1:0] Data_Mem_read = '0;
  logic ready_mem = 1'b0;
  logic busy, grant_instr;

  mem_port_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
    .clk(clk), .reset(reset),
    .read_Mem_data(read_Mem_data), .write_Mem_data(write_Mem_data),
    .Addr_Mem_data(Addr_Mem_data), .Data_Mem_data_write(Data_Mem_data_write),
    .Data_Mem_data_read(Data_Mem_data_read), .ready_mem_data(ready_mem_data),
    .read_Mem_instr(read_Mem_instr), .write_Mem_instr(write_Mem_instr),
    .Addr_Mem_instr(Addr_Mem_instr), .Data_Mem_instr_write(Data_Mem_instr_write),
    .Data_Mem_instr_read(Data_Mem_instr_read), .ready_mem_instr(ready_mem_instr),
    .read_Mem(read_Mem), .write_Mem(write_Mem), .Addr_Mem(Addr_Mem),
    .Data_Mem_write(Data_Mem_write), .Data_Mem_read(Data_Mem_read),
    .ready_mem(ready_mem), .busy(busy), .grant_instr(grant_instr)
  );

  always #5 clk = ~clk;

  typedef struct { bit instr; bit wr; logic [31:0] addr; logic [127:0] wdata; } issue_t;
  typedef struct { bit instr; bit rd; logic [127:0] data; } done_t;
  issue_t issue_q[$];
  done_t  done_q[$];

  int errors = 0;
  int checks = 0;
  int mem_lat = 3;
  bit spurious = 1'b0;
  logic [127:0] exp_dread = '0, exp_iread = '0;
  int cyc = 0, strobe_len = 0, last_strobe_len = 0, last_issue_cyc = -1000, min_gap = 1000;

  function automatic logic [127:0] rline(input logic [31:0] a);
    return {32'hDEADBEEF, a, ~a, 32'h600DF00D};
  endfunction

  function automatic logic [127:0] wline(input logic [31:0] a);
    return {4{a ^ 32'h0BAD0000}};
  endfunction

  task automatic expect_txn(input bit instr, input bit rd, input bit wr,
                            input logic [31:0] a, input logic [127:0] wd);
    issue_t e;
    done_t d;
    e.instr = instr; e.wr = wr; e.addr = a; e.wdata = wd;
    d.instr = instr; d.rd = rd & ~wr; d.data = rline(a);
    issue_q.push_back(e);
    done_q.push_back(d);
  endtask

  task automatic drive(input bit instr, input logic rd, input logic wr,
                       input logic [31:0] a, input logic [127:0] wd);
    if (instr) begin
      read_Mem_instr = rd; write_Mem_instr = wr; Addr_Mem_instr = a; Data_Mem_instr_write = wd;
    end else begin
      read_Mem_data = rd; write_Mem_data = wr; Addr_Mem_data = a; Data_Mem_data_write = wd;
    end
  endtask

  task automatic wait_done(input bit instr);
    int t;
    for (t = 0; t < 400; t++) begin
      @(negedge clk);
      if (instr ? ready_mem_instr : ready_mem_data) break;
    end
    checks++;
    if (t >= 400) begin
      errors++;
      $display("FAIL ready_timeout instr=%0d: no ready pulse within 400 cycles, required one", instr);
    end
  endtask

  task automatic requester(input bit instr, input int n, input logic [31:0] base,
                           input logic rd, input logic wr, input logic [127:0] wd);
    @(negedge clk);
    for (int r = 0; r < n; r++) begin
      drive(instr, rd, wr, base + 32'(r) * 32'h40, wd);
      wait_done(instr);
    end
    drive(instr, 1'b0, 1'b0, 32'h0, 128'h0);
  endtask

  task automatic check_drained(input string tag);
    repeat (3) @(negedge clk);
    checks++;
    if (issue_q.size() != 0 || done_q.size() != 0) begin
      errors++;
      $display("FAIL drained_%s: pending issue=%0d done=%0d, required 0 0", tag, issue_q.size(), done_q.size());
    end
  endtask

  // Memory model: ready_mem on the (mem_lat+1)-th strobe cycle, junk data otherwise
  initial begin
    int cnt;
    cnt = 0;
    forever begin
      @(negedge clk);
      if (read_Mem || write_Mem) begin
        ready_mem = (cnt == mem_lat) || spurious;
        Data_Mem_read = ready_mem ? rline(Addr_Mem) : {4{$urandom}};
        cnt++;
      end else begin
        cnt = 0;
        ready_mem = spurious;
        Data_Mem_read = {4{$urandom}};
      end
    end
  end

  // Monitor: issue/done scoreboards, hold checks, read-register and busy tracking
  initial begin
    issue_t e;
    done_t d;
    logic strobe, prev_strobe, prev_rd, prev_wr;
    logic [31:0] prev_addr;
    logic [127:0] prev_wdata;
    prev_strobe = 1'b0; prev_rd = 1'b0; prev_wr = 1'b0; prev_addr = '0; prev_wdata = '0;
    forever begin
      @(negedge clk);
      cyc++;
      strobe = read_Mem | write_Mem;
      if (!reset) begin
        if (strobe && !prev_strobe) begin
          checks++;
          if (issue_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_issue: addr=%h wr=%0d, required no issue", Addr_Mem, write_Mem);
          end else begin
            e = issue_q.pop_front();
            if ({grant_instr, write_Mem, read_Mem, Addr_Mem} !== {e.instr, e.wr, ~e.wr, e.addr}) begin
              errors++;
              $display("FAIL issue: got grant=%0d wr=%0d rd=%0d addr=%h, required grant=%0d wr=%0d rd=%0d addr=%h",
                       grant_instr, write_Mem, read_Mem, Addr_Mem, e.instr, e.wr, ~e.wr, e.addr);
            end
            if (e.wr) begin
              checks++;
              if (Data_Mem_write !== e.wdata) begin
                errors++;
                $display("FAIL issue_wdata: got %h, required %h", Data_Mem_write, e.wdata);
              end
            end
          end
          if (cyc - last_issue_cyc < min_gap) min_gap = cyc - last_issue_cyc;
          last_issue_cyc = cyc;
        end
        if (strobe && prev_strobe) begin
          checks++;
          if ({read_Mem, write_Mem, Addr_Mem, Data_Mem_write} !== {prev_rd, prev_wr, prev_addr, prev_wdata}) begin
            errors++;
            $display("FAIL busy_hold: got rd=%0d wr=%0d addr=%h, required rd=%0d wr=%0d addr=%h",
                     read_Mem, write_Mem, Addr_Mem, prev_rd, prev_wr, prev_addr);
          end
        end
        if (ready_mem_data || ready_mem_instr) begin
          checks++;
          if (done_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_ready: got data=%0d instr=%0d, required none", ready_mem_data, ready_mem_instr);
          end else begin
            d = done_q.pop_front();
            if ({ready_mem_instr, ready_mem_data} !== {d.instr, ~d.instr}) begin
              errors++;
              $display("FAIL ready_owner: got instr=%0d data=%0d, required instr=%0d data=%0d",
                       ready_mem_instr, ready_mem_data, d.instr, ~d.instr);
            end
            if (d.rd && d.instr) exp_iread = d.data;
            if (d.rd && !d.instr) exp_dread = d.data;
          end
        end
        checks++;
        if ({Data_Mem_data_read, Data_Mem_instr_read} !== {exp_dread, exp_iread}) begin
          errors++;
          $display("FAIL read_regs: got d=%h i=%h, required d=%h i=%h",
                   Data_Mem_data_read, Data_Mem_instr_read, exp_dread, exp_iread);
        end
        checks++;
        if (busy !== (strobe | ready_mem_data | ready_mem_instr)) begin
          errors++;
          $display("FAIL busy: got %0d, required %0d", busy, strobe | ready_mem_data | ready_mem_instr);
        end
      end
      if (strobe) strobe_len++;
      else if (prev_strobe) begin
        last_strobe_len = strobe_len;
        strobe_len = 0;
      end
      prev_strobe = strobe; prev_rd = read_Mem; prev_wr = write_Mem;
      prev_addr = Addr_Mem; prev_wdata = Data_Mem_write;
    end
  end

  task automatic apply_reset(input int n);
    @(negedge clk);
    reset = 1'b1;
    issue_q.delete();
    done_q.delete();
    exp_dread = '0;
    exp_iread = '0;
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    drive(1'b0, 1'b1, 1'b0, 32'h0000_0800, 128'h0);
    drive(1'b1, 1'b1, 1'b0, 32'h0000_0900, 128'h0);
    repeat (2) @(negedge clk);
    checks++;
    if ({read_Mem, write_Mem, Addr_Mem, Data_Mem_write, Data_Mem_data_read, Data_Mem_instr_read,
         ready_mem_data, ready_mem_instr, busy, grant_instr} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got rd=%0d wr=%0d addr=%h busy=%0d grant=%0d, required all 0",
               read_Mem, write_Mem, Addr_Mem, busy, grant_instr);
    end
    drive(1'b1, 1'b0, 1'b0, 32'h0, 128'h0);
    expect_txn(1'b0, 1'b1, 1'b0, 32'h0000_0800, 128'h0);
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (read_Mem !== 1'b1) begin
      errors++;
      $display("FAIL reset_first_issue: got read_Mem=%0d one cycle after reset, required 1", read_Mem);
    end
    wait_done(1'b0);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 128'h0);
    check_drained("reset");
  endtask

  task automatic test_lone_read();
    mem_lat = 3;
    expect_txn(1'b0, 1'b1, 1'b0, 32'h0000_1040, 128'h0);
    requester(1'b0, 1, 32'h0000_1040, 1'b1, 1'b0, 128'h0);
    @(negedge clk);
    checks++;
    if (last_strobe_len !== 4 || ready_mem_data !== 1'b0) begin
      errors++;
      $display("FAIL lone_read_timing: got strobe_len=%0d ready_after=%0d, required 4 0", last_strobe_len, ready_mem_data);
    end
    checks++;
    if (Data_Mem_data_read !== rline(32'h0000_1040)) begin
      errors++;
      $display("FAIL lone_read_data: got %h, required %h", Data_Mem_data_read, rline(32'h0000_1040));
    end
    check_drained("lone_read");
  endtask

  task automatic test_simultaneous();
    mem_lat = 2;
    expect_txn(1'b0, 1'b0, 1'b1, 32'h0000_0300, {16{8'hA5}});
    expect_txn(1'b1, 1'b1, 1'b0, 32'h0000_0200, 128'h0);
    fork
      requester(1'b0, 1, 32'h0000_0300, 1'b0, 1'b1, {16{8'hA5}});
      requester(1'b1, 1, 32'h0000_0200, 1'b1, 1'b0, 128'h0);
    join
    check_drained("simultaneous");
  endtask

  task automatic test_back_to_back();
    apply_reset(2);
    reset = 1'b0;
    mem_lat = 0;
    min_gap = 1000;
    last_issue_cyc = -1000;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    for (int r = 0; r < 4; r++) begin
      expect_txn(1'b0, 1'b1, 1'b0, 32'h0000_1000 + 32'(r) * 32'h40, 128'h0);
      expect_txn(1'b1, 1'b1, 1'b0, 32'h0000_2000 + 32'(r) * 32'h40, 128'h0);
    end
`else
    for (int r = 0; r < 4; r++) expect_txn(1'b0, 1'b1, 1'b0, 32'h0000_1000 + 32'(r) * 32'h40, 128'h0);
    for (int r = 0; r < 4; r++) expect_txn(1'b1, 1'b1, 1'b0, 32'h0000_2000 + 32'(r) * 32'h40, 128'h0);
`endif
    fork
      requester(1'b0, 4, 32'h0000_1000, 1'b1, 1'b0, 128'h0);
      requester(1'b1, 4, 32'h0000_2000, 1'b1, 1'b0, 128'h0);
    join
    check_drained("back_to_back");
    checks++;
    if (min_gap !== 3) begin
      errors++;
      $display("FAIL issue_gap: got minimum %0d cycles between issues, required 3", min_gap);
    end
  endtask

  task automatic test_reset_mid_busy();
    issue_t e;
    int t;
    mem_lat = 3;
    e.instr = 1'b0; e.wr = 1'b0; e.addr = 32'h0000_1400; e.wdata = 128'h0;
    issue_q.push_back(e);
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b0, 32'h0000_1400, 128'h0);
    for (t = 0; t < 20; t++) begin
      @(negedge clk);
      if (read_Mem) break;
    end
    @(negedge clk);
    reset = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 128'h0);
    issue_q.delete();
    done_q.delete();
    exp_dread = '0;
    exp_iread = '0;
    @(negedge clk);
    checks++;
    if ({read_Mem, write_Mem, ready_mem_data, busy} !== 4'b0000 || t >= 20) begin
      errors++;
      $display("FAIL reset_mid_busy: got rd=%0d wr=%0d ready=%0d busy=%0d (issue wait %0d), required 0 0 0 0",
               read_Mem, write_Mem, ready_mem_data, busy, t);
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (6) @(negedge clk);
    expect_txn(1'b0, 1'b1, 1'b0, 32'h0000_1480, 128'h0);
    requester(1'b0, 1, 32'h0000_1480, 1'b1, 1'b0, 128'h0);
    check_drained("reset_mid_busy");
  endtask

  task automatic test_corner();
    spurious = 1'b1;
    repeat (4) begin
      @(negedge clk);
      checks++;
      if ({ready_mem_data, ready_mem_instr, busy} !== 3'b000) begin
        errors++;
        $display("FAIL idle_ready_mem: got ready_d=%0d ready_i=%0d busy=%0d, required 0 0 0",
                 ready_mem_data, ready_mem_instr, busy);
      end
    end
    spurious = 1'b0;
    repeat (2) @(negedge clk);
    mem_lat = 1;
    expect_txn(1'b0, 1'b1, 1'b1, 32'h0000_0500, wline(32'h0000_0500));
    requester(1'b0, 1, 32'h0000_0500, 1'b1, 1'b1, wline(32'h0000_0500));
    check_drained("rd_wr_together");
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_lone_read();
    test_simultaneous();
    test_back_to_back();
    test_reset_mid_busy();
    test_corner();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
